// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry queue of {pc, instr} pairs with push, pop, flush and count
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is not reset: an entry is only observable while count covers it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, redirect/flush control and decode queue
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          pop;
  logic          push;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  logic          unused_redirect_lsbs;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // When full, a slot frees up only if decode takes the head this same cycle.
  assign push      = !redirect_valid & ((count < CW'(DEPTH)) | pop);

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ('{pc: fetch_pc, instr: fetch_instr}),
    .rdata (head),
    .count (count)
  );

  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      fetch_pc <= fetch_pc + INSTR_BYTES;
    end
  end

`ifdef FETCH_PERF_EN
  // A head popped alongside the redirect was consumed, so it is not counted as flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push)           perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid) perf_flushed <= perf_flushed + 32'(count) - 32'(pop);
    end
  end
`endif

endmodule
